// File: rtl/matmul_acc_pkg.sv
// Shared types and index helpers for the sequential matrix-multiply accelerator.
//   state_e : controller states
//   acc_w   : result element width for a given operand width and dimension
//   cnt_w   : counter width for a range (minimum 1 bit)
//   idx     : flat index of element (r,c) in an n x n row-major array
package matmul_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int acc_w(input int dat_w, input int mat_n);
    return 2 * dat_w + $clog2(mat_n);
  endfunction

  function automatic int cnt_w(input int range);
    return (range <= 1) ? 1 : $clog2(range);
  endfunction

  function automatic int idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matmul_mac_lane.sv
// One multiply-accumulate lane. Each cycle computes (seed or running acc) + a*b.
//   clk, rst_n  : clock, async active-low reset
//   a_i, b_i    : operand elements
//   signed_i    : 1 = two's-complement operands
//   seed_i      : value the sum starts from when first_i is high
//   first_i     : first k step of a dot product
//   last_i      : last k step; the sum is to be written to C this cycle
//   sum_o       : acc + product for the current step
//   wr_o        : write strobe for sum_o
module matmul_mac_lane #(
  parameter int DAT_W = 8,
  parameter int ACC_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DAT_W-1:0] a_i,
  input  logic [DAT_W-1:0] b_i,
  input  logic             signed_i,
  input  logic [ACC_W-1:0] seed_i,
  input  logic             first_i,
  input  logic             last_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             wr_o
);

  localparam int P_W = 2 * DAT_W;

  logic [P_W-1:0]   a_ext, b_ext, prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_q, acc_d;

  // The low 2*DAT_W bits of a signed product equal the unsigned product of the
  // sign-extended operands, so one multiplier serves both modes.
  always_comb begin
    a_ext    = signed_i ? {{DAT_W{a_i[DAT_W-1]}}, a_i} : {{DAT_W{1'b0}}, a_i};
    b_ext    = signed_i ? {{DAT_W{b_i[DAT_W-1]}}, b_i} : {{DAT_W{1'b0}}, b_i};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_W-P_W){signed_i & prod[P_W-1]}}, prod};
    acc_d    = (first_i ? seed_i : acc_q) + prod_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign sum_o = acc_d;
  assign wr_o  = last_i;

endmodule

// File: rtl/matmul_acc_seq.sv
// Sequential matrix-multiply accelerator: C = A*B, or C += A*B in accumulate mode.
// Steps row i (outer), column group g, k (inner); LANES lanes cover columns g*LANES+l.
//   clk, rst_n : clock, async active-low reset
//   start_i    : start request, honoured in IDLE only
//   signed_i   : two's-complement operands (latched at start)
//   accum_i    : accumulate into existing C (latched at start)
//   mat_a_i    : A, element (r,c) at r*MAT_N+c, read live
//   mat_b_i    : B, same layout
//   mat_c_o    : registered result C, same layout
//   busy_o     : operation in progress (RUN and DONE)
//   done_o     : single-cycle completion pulse
module matmul_acc_seq
  import matmul_acc_pkg::*;
#(
  parameter int  DAT_W = 8,
  parameter int  MAT_N = 2,
  parameter int  LANES = 1,
  localparam int ACC_W = acc_w(DAT_W, MAT_N)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_i,
  input  logic                                 signed_i,
  input  logic                                 accum_i,
  input  logic [MAT_N*MAT_N-1:0][DAT_W-1:0]    mat_a_i,
  input  logic [MAT_N*MAT_N-1:0][DAT_W-1:0]    mat_b_i,
  output logic [MAT_N*MAT_N-1:0][ACC_W-1:0]    mat_c_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int NE  = MAT_N * MAT_N;
  localparam int GRP = MAT_N / LANES;
  localparam int IW  = cnt_w(MAT_N);
  localparam int GW  = cnt_w(GRP);
  localparam int XW  = cnt_w(NE);

  state_e                    state_q, state_d;
  logic [IW-1:0]             i_q, i_d, k_q, k_d;
  logic [GW-1:0]             g_q, g_d;
  logic                      signed_q, signed_d, accum_q, accum_d;
  logic [NE-1:0][ACC_W-1:0]  c_q, c_d;

  logic k_last, g_last, i_last, run;
  logic [XW-1:0]    a_idx;
  logic [XW-1:0]    c_idx [LANES];
  logic [ACC_W-1:0] sum   [LANES];
  logic [LANES-1:0] wr;

  assign k_last = (k_q == IW'(MAT_N - 1));
  assign g_last = (g_q == GW'(GRP - 1));
  assign i_last = (i_q == IW'(MAT_N - 1));
  assign run    = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    g_d      = g_q;
    k_d      = k_q;
    signed_d = signed_q;
    accum_d  = accum_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          i_d      = '0;
          g_d      = '0;
          k_d      = '0;
          signed_d = signed_i;
          accum_d  = accum_i;
        end
      end
      RUN: begin
        if (k_last) begin
          k_d = '0;
          if (g_last) begin
            g_d = '0;
            if (i_last) begin
              i_d     = '0;
              state_d = DONE;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            g_d = g_q + GW'(1);
          end
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign a_idx = XW'(idx(int'(i_q), int'(k_q), MAT_N));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [XW-1:0]    b_idx;
    logic [ACC_W-1:0] seed;

    assign c_idx[l] = XW'(idx(int'(i_q), int'(g_q) * LANES + l, MAT_N));
    assign b_idx    = XW'(idx(int'(k_q), int'(g_q) * LANES + l, MAT_N));
    // C[i][j] is still the pre-op value here: it is only overwritten at k=MAT_N-1.
    assign seed     = accum_q ? c_q[c_idx[l]] : '0;

    matmul_mac_lane #(
      .DAT_W (DAT_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_i      (mat_a_i[a_idx]),
      .b_i      (mat_b_i[b_idx]),
      .signed_i (signed_q),
      .seed_i   (seed),
      .first_i  (k_q == '0),
      .last_i   (run && k_last),
      .sum_o    (sum[l]),
      .wr_o     (wr[l])
    );
  end

  always_comb begin
    c_d = c_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (wr[l]) c_d[c_idx[l]] = sum[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      g_q      <= '0;
      k_q      <= '0;
      signed_q <= 1'b0;
      accum_q  <= 1'b0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      g_q      <= g_d;
      k_q      <= k_d;
      signed_q <= signed_d;
      accum_q  <= accum_d;
      c_q      <= c_d;
    end
  end

  assign mat_c_o = c_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

endmodule
